// File: rtl/rv64g_l1_refill_engine.sv
// rv64g_l1_refill_engine: TileLink-C line refill sequencer (AcquireBlock, GrantData x8, GrantAck) with tag install
module rv64g_l1_refill_engine #(
    parameter int           TAG_W     = 53,
    parameter int           INDEX_W   = 5,
    parameter logic [3:0]   SOURCE_ID = 4'd0,
    parameter int           SINK_W    = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               refill_req_i,
    input  logic [63:0]        refill_addr_i,
    input  logic               refill_perm_i,
    output logic               refill_done_o,
    output logic               refill_err_o,
    output logic               busy_o,
    output logic               a_valid_o,
    input  logic               a_ready_i,
    output logic [2:0]         a_opcode_o,
    output logic [2:0]         a_param_o,
    output logic [2:0]         a_size_o,
    output logic [3:0]         a_source_o,
    output logic [63:0]        a_address_o,
    input  logic               d_valid_i,
    output logic               d_ready_o,
    input  logic [2:0]         d_opcode_i,
    input  logic [1:0]         d_param_i,
    input  logic [SINK_W-1:0]  d_sink_i,
    input  logic               d_denied_i,
    input  logic [63:0]        d_data_i,
    output logic               e_valid_o,
    input  logic               e_ready_i,
    output logic [SINK_W-1:0]  e_sink_o,
    output logic               wr_en_o,
    output logic [INDEX_W-1:0] wr_index_o,
    output logic [2:0]         wr_beat_o,
    output logic [63:0]        wr_data_o,
    output logic               tag_wr_o,
    output logic [TAG_W-1:0]   tag_o,
    output logic [1:0]         state_o
);
    typedef enum logic [2:0] {IDLE, ACQ, BEATS, ACK, DONE} state_e;

    state_e             state_q, state_d;
    logic [63:0]        addr_q;
    logic               perm_q, denied_q;
    logic [2:0]         beat_q;
    logic [SINK_W-1:0]  sink_q;
    logic [1:0]         param_q;
    logic               grant_data, grant, last;

    // D-channel beat classification; only meaningful while in BEATS
    assign grant_data = state_q == BEATS && d_valid_i && d_opcode_i == 3'd5;
    assign grant      = state_q == BEATS && d_valid_i && d_opcode_i == 3'd4;
    assign last       = grant || (grant_data && beat_q == 3'd7);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Request latch, beat counter and grant bookkeeping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q   <= '0;
            perm_q   <= 1'b0;
            beat_q   <= '0;
            denied_q <= 1'b0;
            sink_q   <= '0;
            param_q  <= '0;
        end else begin
            if (state_q == IDLE && refill_req_i) begin
                addr_q   <= refill_addr_i & ~64'h3f;
                perm_q   <= refill_perm_i;
                beat_q   <= '0;
                denied_q <= 1'b0;
            end
            if (grant_data) beat_q <= beat_q + 3'd1;
            if (grant_data || grant) denied_q <= denied_q | d_denied_i;
            if (last) begin
                sink_q  <= d_sink_i;
                param_q <= d_param_i;
            end
        end
    end

    // Next state and channel/array decodes; everything idles at zero
    always_comb begin
        state_d       = state_q;
        busy_o        = state_q != IDLE;
        refill_done_o = 1'b0;
        refill_err_o  = 1'b0;
        a_valid_o     = 1'b0;
        a_opcode_o    = '0;
        a_param_o     = '0;
        a_size_o      = '0;
        a_source_o    = '0;
        a_address_o   = '0;
        d_ready_o     = 1'b0;
        e_valid_o     = 1'b0;
        e_sink_o      = '0;
        wr_en_o       = 1'b0;
        wr_index_o    = '0;
        wr_beat_o     = '0;
        wr_data_o     = '0;
        tag_wr_o      = 1'b0;
        tag_o         = '0;
        state_o       = '0;
        case (state_q)
            IDLE: state_d = refill_req_i ? ACQ : IDLE;
            ACQ: begin
                a_valid_o   = 1'b1;
                a_opcode_o  = 3'd6;
                a_param_o   = {2'b0, perm_q};
                a_size_o    = 3'd6;
                a_source_o  = SOURCE_ID;
                a_address_o = addr_q;
                state_d     = a_ready_i ? BEATS : ACQ;
            end
            BEATS: begin
                d_ready_o  = 1'b1;
                wr_en_o    = grant_data;
                wr_beat_o  = grant_data ? beat_q : '0;
                wr_data_o  = grant_data ? d_data_i : '0;
                wr_index_o = grant_data ? addr_q[6+:INDEX_W] : '0;
                state_d    = last ? ACK : BEATS;
            end
            ACK: begin
                e_valid_o = 1'b1;
                e_sink_o  = sink_q;
                tag_wr_o  = e_ready_i && !denied_q;
                tag_o     = addr_q[63-:TAG_W];
                state_o   = param_q == 2'd0 ? 2'b10 : 2'b01;
                state_d   = e_ready_i ? DONE : ACK;
            end
            DONE: begin
                refill_done_o = 1'b1;
                refill_err_o  = denied_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_rv64g_l1_refill_engine.sv
// tb_rv64g_l1_refill_engine: directed refills with a queue scoreboard checked by a negedge monitor
module tb_rv64g_l1_refill_engine;
    logic        clk_i = 1'b0, rst_ni = 1'b0;
    logic        refill_req_i = 1'b0, refill_perm_i = 1'b0;
    logic [63:0] refill_addr_i = '0;
    logic        refill_done_o, refill_err_o, busy_o;
    logic        a_valid_o, a_ready_i = 1'b0;
    logic [2:0]  a_opcode_o, a_param_o, a_size_o;
    logic [3:0]  a_source_o;
    logic [63:0] a_address_o;
    logic        d_valid_i = 1'b0, d_ready_o, d_denied_i = 1'b0;
    logic [2:0]  d_opcode_i = '0;
    logic [1:0]  d_param_i = '0;
    logic [3:0]  d_sink_i = '0;
    logic [63:0] d_data_i = '0;
    logic        e_valid_o, e_ready_i = 1'b0;
    logic [3:0]  e_sink_o;
    logic        wr_en_o;
    logic [4:0]  wr_index_o;
    logic [2:0]  wr_beat_o;
    logic [63:0] wr_data_o;
    logic        tag_wr_o;
    logic [52:0] tag_o;
    logic [1:0]  state_o;

    rv64g_l1_refill_engine dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .refill_req_i(refill_req_i), .refill_addr_i(refill_addr_i), .refill_perm_i(refill_perm_i),
        .refill_done_o(refill_done_o), .refill_err_o(refill_err_o), .busy_o(busy_o),
        .a_valid_o(a_valid_o), .a_ready_i(a_ready_i), .a_opcode_o(a_opcode_o), .a_param_o(a_param_o),
        .a_size_o(a_size_o), .a_source_o(a_source_o), .a_address_o(a_address_o),
        .d_valid_i(d_valid_i), .d_ready_o(d_ready_o), .d_opcode_i(d_opcode_i), .d_param_i(d_param_i),
        .d_sink_i(d_sink_i), .d_denied_i(d_denied_i), .d_data_i(d_data_i),
        .e_valid_o(e_valid_o), .e_ready_i(e_ready_i), .e_sink_o(e_sink_o),
        .wr_en_o(wr_en_o), .wr_index_o(wr_index_o), .wr_beat_o(wr_beat_o), .wr_data_o(wr_data_o),
        .tag_wr_o(tag_wr_o), .tag_o(tag_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    int cnt = 0;
    always @(posedge clk_i) cnt <= cnt + 1;

    int errors = 0, checks = 0;
    logic [66:0] a_q[$];
    logic [71:0] w_q[$];
    logic [3:0]  e_q[$];
    logic [54:0] t_q[$];
    logic [32:0] d_q[$];
    logic [66:0] ea;
    logic [71:0] ew;
    logic [54:0] et;
    logic [32:0] ed;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cnt);
        end
    endtask

    function automatic logic [63:0] beat_data(input logic [63:0] line, input int i);
        return {line[31:0] ^ 32'hDEAD_BEEF, 32'(32'h11 * i)};
    endfunction

    // Monitor: every handshake or strobe pops the next expected item
    always @(negedge clk_i) begin
        if (a_valid_o && a_ready_i) begin
            chk("a_expected", 64'(a_q.size() != 0), 64'd1);
            if (a_q.size() != 0) begin
                ea = a_q.pop_front();
                chk("a_address", a_address_o, ea[66:3]);
                chk("a_param", 64'(a_param_o), 64'(ea[2:0]));
                chk("a_opcode", 64'(a_opcode_o), 64'd6);
                chk("a_size", 64'(a_size_o), 64'd6);
                chk("a_source", 64'(a_source_o), 64'd0);
            end
        end
        if (wr_en_o) begin
            chk("wr_expected", 64'(w_q.size() != 0), 64'd1);
            if (w_q.size() != 0) begin
                ew = w_q.pop_front();
                chk("wr_beat", 64'(wr_beat_o), 64'(ew[71:69]));
                chk("wr_index", 64'(wr_index_o), 64'(ew[68:64]));
                chk("wr_data", wr_data_o, ew[63:0]);
            end
        end
        if (e_valid_o && e_ready_i) begin
            chk("e_expected", 64'(e_q.size() != 0), 64'd1);
            if (e_q.size() != 0) chk("e_sink", 64'(e_sink_o), 64'(e_q.pop_front()));
        end
        if (tag_wr_o) begin
            chk("tag_expected", 64'(t_q.size() != 0), 64'd1);
            if (t_q.size() != 0) begin
                et = t_q.pop_front();
                chk("tag", 64'(tag_o), 64'(et[54:2]));
                chk("state", 64'(state_o), 64'(et[1:0]));
            end
        end
        if (refill_done_o) begin
            chk("done_expected", 64'(d_q.size() != 0), 64'd1);
            if (d_q.size() != 0) begin
                ed = d_q.pop_front();
                chk("done_err", 64'(refill_err_o), 64'(ed[32]));
                chk("done_cycle", 64'(cnt), 64'(ed[31:0]));
            end
        end
    end

    task automatic chk_quiet(input string name);
        chk(name, 64'({busy_o, a_valid_o, d_ready_o, e_valid_o, wr_en_o, tag_wr_o, refill_done_o, refill_err_o}), 64'd0);
        chk({name, "_buses"}, a_address_o | wr_data_o | 64'(tag_o) | 64'(e_sink_o) | 64'(state_o) | 64'(a_opcode_o), 64'd0);
    endtask

    // One refill; lat is the hand-computed request-to-done distance, ign the beat (8 = DONE) carrying a stray request
    task automatic refill(input logic [63:0] addr, input logic perm, input int a_dly, input logic [7:0] gaps,
                          input int e_dly, input int den, input logic [1:0] cap, input logic dataless,
                          input int lat, input int ign);
        logic [63:0] line;
        logic [3:0]  sink;
        int          t0;
        line = {addr[63:6], 6'b0};
        sink = addr[3:0] ^ 4'h9;
        @(posedge clk_i); #1;
        refill_req_i = 1'b1; refill_addr_i = addr; refill_perm_i = perm; t0 = cnt;
        a_q.push_back({line, 2'b0, perm});
        if (!dataless) for (int i = 0; i < 8; i++) w_q.push_back({3'(i), line[10:6], beat_data(line, i)});
        e_q.push_back(sink);
        if (den < 0) t_q.push_back({line[63:11], cap == 2'd0 ? 2'b10 : 2'b01});
        d_q.push_back({den >= 0, 32'(t0 + lat)});
        @(posedge clk_i); #1;
        refill_req_i = 1'b0; refill_addr_i = '0; refill_perm_i = 1'b0;
        for (int i = 0; i < a_dly; i++) begin
            chk("a_stall_valid", 64'(a_valid_o), 64'd1);
            chk("a_stall_addr", a_address_o, line);
            chk("a_stall_param", 64'(a_param_o), 64'({2'b0, perm}));
            @(posedge clk_i); #1;
        end
        a_ready_i = 1'b1;
        @(posedge clk_i); #1;
        a_ready_i = 1'b0;
        if (dataless) begin
            d_valid_i = 1'b1; d_opcode_i = 3'd4; d_param_i = cap; d_sink_i = sink; d_denied_i = den >= 0;
            @(posedge clk_i); #1;
            d_valid_i = 1'b0; d_denied_i = 1'b0;
            chk("grant_ack_next", 64'(e_valid_o), 64'd1);
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (gaps[i]) begin
                    @(posedge clk_i); #1;
                end
                d_valid_i = 1'b1; d_opcode_i = 3'd5; d_data_i = beat_data(line, i);
                d_denied_i = i == den;
                d_param_i = i == 7 ? cap : ~cap;
                d_sink_i = i == 7 ? sink : ~sink;
                refill_req_i = i == ign; refill_addr_i = ~addr;
                @(posedge clk_i); #1;
                d_valid_i = 1'b0; d_denied_i = 1'b0; refill_req_i = 1'b0; refill_addr_i = '0;
            end
        end
        for (int i = 0; i < e_dly; i++) begin
            chk("e_stall_valid", 64'(e_valid_o), 64'd1);
            chk("e_stall_sink", 64'(e_sink_o), 64'(sink));
            @(posedge clk_i); #1;
        end
        e_ready_i = 1'b1;
        @(posedge clk_i); #1;
        e_ready_i = 1'b0;
        refill_req_i = ign == 8; refill_addr_i = ~addr;
        @(posedge clk_i); #1;
        refill_req_i = 1'b0; refill_addr_i = '0;
        chk("idle_after", 64'(busy_o), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] line;
        repeat (2) @(posedge clk_i);
        #1;
        chk_quiet("reset_state");
        rst_ni = 1'b1;
        // Basic: zero stalls, cap param 1 -> B
        refill(64'h8000_1234, 1'b0, 0, 8'h00, 0, -1, 2'd1, 1'b0, 11, -1);
        // Back-pressure: A +3, two D gaps, E +2; stray request during DONE
        refill(64'h0000_0040_0000_07C0, 1'b0, 3, 8'b0010_0100, 2, -1, 2'd1, 1'b0, 18, 8);
        // Permission NtoT, cap toT; stray request during BEATS
        refill(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0, 8'h00, 0, -1, 2'd0, 1'b0, 11, 2);
        // Denied on beat 3 only: E still sent, no tag write, error reported
        refill(64'h1234_5678_9ABC_DEF0, 1'b1, 0, 8'h00, 0, 3, 2'd0, 1'b0, 11, -1);
        // Dataless Grant, E stalled one cycle
        refill(64'h0000_0000_0000_0800, 1'b0, 0, 8'h00, 1, -1, 2'd2, 1'b1, 5, -1);
        // Reset during beat 4
        line = 64'hCAFE_0000_0000_1000;
        @(posedge clk_i); #1;
        refill_req_i = 1'b1; refill_addr_i = line; refill_perm_i = 1'b0;
        a_q.push_back({line, 3'd0});
        for (int i = 0; i < 4; i++) w_q.push_back({3'(i), line[10:6], beat_data(line, i)});
        @(posedge clk_i); #1;
        refill_req_i = 1'b0; refill_addr_i = '0; a_ready_i = 1'b1;
        @(posedge clk_i); #1;
        a_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d_valid_i = 1'b1; d_opcode_i = 3'd5; d_data_i = beat_data(line, i);
            if (i == 4) begin
                rst_ni = 1'b0;
                #1;
                chk_quiet("reset_mid");
            end
            @(posedge clk_i); #1;
        end
        chk("reset_no_e", 64'(e_valid_o), 64'd0);
        d_valid_i = 1'b0;
        rst_ni = 1'b1;
        refill(64'h0000_0000_1357_9BC0, 1'b1, 0, 8'h00, 0, -1, 2'd1, 1'b0, 11, -1);
        repeat (3) @(posedge clk_i);
        #1;
        chk("a_q_drained", 64'(a_q.size()), 64'd0);
        chk("w_q_drained", 64'(w_q.size()), 64'd0);
        chk("e_q_drained", 64'(e_q.size()), 64'd0);
        chk("t_q_drained", 64'(t_q.size()), 64'd0);
        chk("d_q_drained", 64'(d_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rv64g_l1_refill_engine.md
# rv64g_l1_refill_engine

Services line-refill requests from the L1 vector miss handler (one outstanding at a time) on the TileLink-C link to L2. Each refill is sequenced as AcquireBlock on channel A, eight GrantData beats on channel D written into the L1 data array, then GrantAck on channel E. The block then installs tag and coherence state and pulses `refill_done_o`. It sits inside the L1 cache controller, between the miss handler's refill port and the TL-C master ports.

## Interface
Parameters:
- `TAG_W`, 53: tag bits. `TAG_W + INDEX_W + 6` must equal 64.
- `INDEX_W`, 5: set index bits.
- `SOURCE_ID`, 0: constant `a_source`. 4 bits.
- `SINK_W`, 4: width of the D/E sink field.

Ports:
- `clk_i`  in  1  clock
- `rst_ni`  in  1  reset, asynchronous, active-low
- `refill_req_i`  in  1  request pulse from the miss handler
- `refill_addr_i`  in  64  line address; bits [5:0] are ignored
- `refill_perm_i`  in  1  0 = NtoB (read), 1 = NtoT (write)
- `refill_done_o`  out  1  one-cycle completion pulse
- `refill_err_o`  out  1  valid with `refill_done_o`; 1 if L2 denied the grant
- `busy_o`  out  1  high in every state except IDLE
- `a_valid_o`  out  1  A-channel valid
- `a_ready_i`  in  1  A-channel ready
- `a_opcode_o`  out  3  A opcode
- `a_param_o`  out  3  A param
- `a_size_o`  out  3  A size
- `a_source_o`  out  4  A source
- `a_address_o`  out  64  A address
- `d_valid_i`  in  1  D-channel valid
- `d_ready_o`  out  1  D-channel ready
- `d_opcode_i`  in  3  D opcode
- `d_param_i`  in  2  D param
- `d_sink_i`  in  `SINK_W`  D sink
- `d_denied_i`  in  1  D denied
- `d_data_i`  in  64  D data
- `e_valid_o`  out  1  E-channel valid
- `e_ready_i`  in  1  E-channel ready
- `e_sink_o`  out  `SINK_W`  E sink
- `wr_en_o`  out  1  data-array write strobe
- `wr_index_o`  out  `INDEX_W`  data-array set index
- `wr_beat_o`  out  3  8-byte word within the line
- `wr_data_o`  out  64  data-array write data
- `tag_wr_o`  out  1  tag/state write strobe
- `tag_o`  out  `TAG_W`  tag to install
- `state_o`  out  2  coherence state to install: 01 = B, 10 = T

## Operation
- **States:** IDLE, ACQ, BEATS, ACK, DONE.
- **IDLE:**
  - `refill_req_i` latches the following, then the FSM moves to ACQ:
    - `addr_q = {refill_addr_i[63:6], 6'b0}`
    - the perm bit
  - A request is accepted only in IDLE. A request in any other state is ignored.
- **ACQ:**
  - `a_valid_o = 1`, with `a_opcode_o = 6` (AcquireBlock), `a_param_o = {2'b0, perm}`, `a_size_o = 6`, `a_source_o = SOURCE_ID`, `a_address_o = addr_q`.
  - All A fields stay stable until `a_ready_i`. Then the FSM moves to BEATS.
- **BEATS:**
  - `d_ready_o = 1`. Each D handshake is one beat.
  - **GrantData (5):**
    - Same cycle: `wr_en_o = 1`, `wr_beat_o = beat_q`, `wr_data_o = d_data_i`, `wr_index_o = addr_q[6+:INDEX_W]`.
    - `beat_q` increments. `denied_q |= d_denied_i`.
    - On the beat with `beat_q == 7`: latch `d_sink_i` and `d_param_i`, then go to ACK.
  - **Grant (4):** no data write. Latch sink, param and denied, then go to ACK.
  - **Any other opcode:** accepted and dropped; no state change.
- **ACK:**
  - `e_valid_o = 1`, `e_sink_o = sink_q`, held until `e_ready_i`.
  - In the handshake cycle, `tag_wr_o = !denied_q`, `tag_o = addr_q[63-:TAG_W]`, and `state_o = 10` if the latched cap param is 0 (toT), otherwise `01`. Then go to DONE.
  - GrantAck is sent even when the grant was denied.
- **DONE:** `refill_done_o = 1` and `refill_err_o = denied_q` for exactly one cycle, then go to IDLE.
- **Counter and latches:** `beat_q` and `denied_q` clear on entry to ACQ. `beat_q` is 3 bits and does not wrap within a refill, because the FSM leaves BEATS on the eighth beat.
- **Reset:** at reset, and on reset asserted mid-refill, the FSM returns to IDLE and every output is 0. No E beat is sent, and no partial tag write occurs. Data words already written are harmless because no tag was installed.

## Timing
- The request must be sampled in IDLE at cycle 0. ACQ starts at cycle 1.
- With zero back-pressure: `a_ready_i` at 1, beats at cycles 2–9, `e_ready_i` at 10, done at 11. That is 11 cycles from request to `refill_done_o`.
- Every stall on A, D or E adds exactly its stall cycles.
- All valid/ready outputs and data-array outputs are combinational decodes of registered state plus the current D fields. No output depends on `*_ready_i` within the same cycle except the strobes that are qualified by a handshake.
- The next request can be accepted the cycle after DONE. A request pulse in the same cycle as DONE is ignored.

## Test plan
- **Basic refill:** request addr `0x8000_1234`, perm 0; L2 answers with zero stalls and 8 beats of data `0x11*i`, param 1. Required:
  - A address `0x8000_1200`, param 0.
  - `wr_beat` 0..7 with the matching data; `wr_index` = `0x08`.
  - `tag_wr_o` with `state_o = 01`; done at cycle 11.
- **Back-pressure:** `a_ready_i` delayed 3 cycles; two 1-cycle D gaps; `e_ready_i` delayed 2 cycles. Required: done at cycle 18 and A/E fields stable throughout the stalls.
- **Permission:** perm 1, cap param 0. Required: `a_param_o = 1`, `state_o = 10`.
- **Denied:** `d_denied_i = 1` on beat 3 only. Required: E is still sent, no `tag_wr_o`, and done with `refill_err_o = 1`.
- **Dataless Grant:** Grant opcode 4 arrives. Required: no `wr_en_o`, ACK on the next cycle, done 3 cycles after the grant.
- **Reset and ignored requests:** assert reset during beat 4. Required: all outputs drop to 0, no `e_valid_o`, and a new request afterwards completes normally. Separately, a request pulse during BEATS is ignored.
